machine_ctrl_param: RTL and testbench
=====================================

Name: machine_ctrl_param

Overview:
- Parametrised successor to the CPU control FSM. Sequences instruction fetch, decode, operand access, execute and writeback for the 8-opcode ISA.
- Generalised in three ways: configurable instruction width in fetch beats (IR_WORDS); optional memory wait states via a mem_ready handshake; a resumable halt.
- Also counts retired instructions.
- Sits between the instruction register/ALU datapath and the memory/PC blocks.

Parameters:
- IR_WORDS, 2, number of memory reads per instruction fetch; legal range 1..4.
- WAIT_EN, 1, 1 = memory-access states stall until mem_ready=1; 0 = mem_ready ignored, treated as 1.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the falling edge.
- ena  in  1  asynchronous active-low reset.
- zero  in  1  accumulator-zero flag; sampled in EXEC.
- opcode  in  3  current instruction opcode from the IR; stable from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- run  in  1  resume request; acted on only in HALT.
- inc_pc  out  1  PC increment strobe.
- load_acc  out  1  accumulator load strobe.
- load_pc  out  1  PC load strobe.
- rd  out  1  memory read.
- wr  out  1  memory write.
- load_ir  out  1  IR load strobe; loads one beat.
- datactrl_ena  out  1  drives accumulator onto the data bus.
- halt  out  1  CPU halted.
- instr_cnt  out  CNT_W  retired-instruction count; wraps at 2^CNT_W.

Behaviour:
- Reset (ena=0, asynchronous): FSM enters IDLE, beat counter=0, instr_cnt=0; every output is 0 immediately, including mid-instruction or mid-wait.
- After reset release: IDLE goes to FETCH at the first falling edge with ena=1.
- States are a shared enum: IDLE, FETCH, DECODE, ADDR, OPF, EXEC, WB, TAIL, SKIP, HALT.
- Outputs are decoded from the registered state, beat counter and opcode. Exception: strobes in memory-access states are gated with mem_ready (see below).
- FETCH, beat k = 0..IR_WORDS-1:
  - rd=1, load_ir=1, inc_pc=1 for k>=1.
  - Advance k on completion. After beat IR_WORDS-1 completes, go to DECODE; k returns to 0.
- DECODE: all outputs 0; 1 cycle.
- ADDR: inc_pc=1.
  - opcode=HLT: go to HALT, halt=1 in ADDR; instr_cnt increments.
  - Any other opcode: go to OPF.
- HALT: halt=1, all else 0. run=1 goes to FETCH beat 0. Holds indefinitely otherwise.
- OPF:
  - JMP: load_pc=1.
  - ADD/AND/XOR/LDA: rd=1.
  - STO: datactrl_ena=1.
  - SKZ: all 0.
- EXEC:
  - ADD/AND/XOR/LDA: rd=1, load_acc=1.
  - STO: wr=1, datactrl_ena=1.
  - JMP: load_pc=1.
  - SKZ: all 0. zero=1 goes to SKIP; otherwise go to WB.
  - All opcodes except taken SKZ go to WB.
- WB:
  - STO: datactrl_ena=1.
  - ADD/AND/XOR/LDA: rd=1.
  - Else all 0.
- TAIL: all 0; instr_cnt increments; go to FETCH beat 0.
- SKIP: inc_pc=1 for exactly IR_WORDS cycles, counted on the beat counter; then instr_cnt increments and FSM goes to FETCH beat 0.
- Memory-access states are FETCH beats and EXEC for ADD/AND/XOR/LDA/STO. With WAIT_EN=1:
  - The state is held while mem_ready=0; rd/wr/datactrl_ena stay asserted throughout.
  - inc_pc, load_ir and load_acc assert only in the cycle where mem_ready=1, so each fires exactly once per state.
  - mem_ready outside memory-access states is ignored.
- Cycle counts with no wait states:
  - Normal instruction: IR_WORDS+6 cycles.
  - Taken SKZ: 2*IR_WORDS+4 cycles.
  - HLT: IR_WORDS+2 cycles, then HALT.
- Opcodes not in the ISA (none exist with 3 bits) and illegal states both go to IDLE with outputs 0.
- instr_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package holds:
  - opcode constants: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7;
  - the state enum;
  - the opcode-class helper is_alu_or_lda.
- No sub-module needed. An inline beat counter of width clog2(IR_WORDS+1) is shared by FETCH and SKIP.

Test Plan:
- IR_WORDS=2, WAIT_EN=0, opcode=ADD, reset released -> 8-cycle loop.
  - Fetch beats: rd/load_ir in cycles 1–2; inc_pc in cycle 2.
  - inc_pc in ADDR; load_acc=1 only in EXEC.
  - instr_cnt=1 after TAIL.
- opcode=HLT -> halt=1 from ADDR onward, held for 20 cycles with run=0. run=1 pulse -> FETCH beat 0 next cycle, halt=0; instr_cnt incremented once.
- SKZ with zero=1, IR_WORDS=3 -> exactly 3 inc_pc pulses in SKIP, 10 cycles total. SKZ with zero=0 -> no SKIP, 9 cycles.
- WAIT_EN=1, STO, mem_ready low 3 cycles in EXEC -> wr and datactrl_ena held 4 cycles; FSM advances only after the mem_ready=1 cycle.
- WAIT_EN=1, fetch beat 1 stalled 2 cycles -> inc_pc and load_ir each asserted exactly once, in the mem_ready cycle.
- ena dropped mid-EXEC of LDA -> all outputs 0 asynchronously, instr_cnt=0. Release -> IDLE, then FETCH beat 0. CNT_W=4: 16 retirements -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/machine_ctrl_param_pkg.sv
// Shared definitions for the parametrised CPU control sequencer.
//   - 3-bit opcode constants of the 8-opcode ISA
//   - state_e: the sequencer state enum
//   - is_alu_or_lda: opcode-class helper for instructions that read an operand
//     from memory and load the accumulator
package machine_ctrl_param_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    ADDR,
    OPF,
    EXEC,
    WB,
    TAIL,
    SKIP,
    HALT
  } state_e;

  function automatic logic is_alu_or_lda(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/machine_ctrl_param_if.sv
// Memory-side bus of the control sequencer.
//   rd           : memory read request
//   wr           : memory write request
//   datactrl_ena : drive accumulator onto the data bus
//   mem_ready    : memory completes the current read/write this cycle
// master = the sequencer, slave = the memory/datapath side.
interface machine_ctrl_param_if;

  logic rd;
  logic wr;
  logic datactrl_ena;
  logic mem_ready;

  modport master (
    output rd,
    output wr,
    output datactrl_ena,
    input  mem_ready
  );

  modport slave (
    input  rd,
    input  wr,
    input  datactrl_ena,
    output mem_ready
  );

endinterface

// File: rtl/machine_ctrl_param.sv
// Parametrised CPU control sequencer: fetch (IR_WORDS beats), decode, operand
// access, execute, writeback, with optional memory wait states, a resumable
// halt and a retired-instruction counter. All state updates on the falling
// edge of clk; ena is an asynchronous active-low reset.
//
// Ports:
//   clk        in   system clock (falling-edge active)
//   ena        in   asynchronous active-low reset
//   zero       in   accumulator-zero flag, sampled in EXEC
//   opcode     in   current opcode from the IR, stable from DECODE onward
//   run        in   resume request, acted on only in HALT
//   bus        mst  rd / wr / datactrl_ena out, mem_ready in
//   inc_pc     out  PC increment strobe
//   load_acc   out  accumulator load strobe
//   load_pc    out  PC load strobe
//   load_ir    out  IR load strobe (one beat)
//   halt       out  CPU halted
//   instr_cnt  out  retired-instruction count, wraps at 2^CNT_W
module machine_ctrl_param
  import machine_ctrl_param_pkg::*;
#(
  parameter int unsigned IR_WORDS = 2,
  parameter bit          WAIT_EN  = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  ena,
  input  logic                  zero,
  input  logic [2:0]            opcode,
  input  logic                  run,
  machine_ctrl_param_if.master  bus,
  output logic                  inc_pc,
  output logic                  load_acc,
  output logic                  load_pc,
  output logic                  load_ir,
  output logic                  halt,
  output logic [CNT_W-1:0]      instr_cnt
);

  localparam int unsigned     BEAT_W    = $clog2(IR_WORDS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IR_WORDS - 1);

  state_e              state;
  state_e              state_nx;
  logic [BEAT_W-1:0]   beat;
  logic [BEAT_W-1:0]   beat_nx;
  logic                retire;
  logic                mem_ok;

  // With wait states disabled every memory access completes in one cycle.
  assign mem_ok = WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(negedge clk or negedge ena) begin
    if (!ena) begin
      state     <= IDLE;
      beat      <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx         = state;
    beat_nx          = beat;
    retire           = 1'b0;
    inc_pc           = 1'b0;
    load_acc         = 1'b0;
    load_pc          = 1'b0;
    load_ir          = 1'b0;
    halt             = 1'b0;
    bus.rd           = 1'b0;
    bus.wr           = 1'b0;
    bus.datactrl_ena = 1'b0;

    case (state)
      IDLE: begin
        state_nx = FETCH;
        beat_nx  = '0;
      end

      // rd is held for the whole access; the one-shot strobes fire only in
      // the completing cycle so a stalled beat loads/increments exactly once.
      // Beat 0 reads at the current PC, later beats advance it first.
      FETCH: begin
        bus.rd  = 1'b1;
        load_ir = mem_ok;
        inc_pc  = mem_ok && (beat != '0);
        if (mem_ok) begin
          if (beat == LAST_BEAT) begin
            beat_nx  = '0;
            state_nx = DECODE;
          end else begin
            beat_nx = beat + BEAT_W'(1);
          end
        end
      end

      DECODE: begin
        state_nx = ADDR;
      end

      ADDR: begin
        inc_pc = 1'b1;
        if (opcode == HLT) begin
          halt     = 1'b1;
          retire   = 1'b1;
          state_nx = HALT;
        end else begin
          state_nx = OPF;
        end
      end

      HALT: begin
        halt = 1'b1;
        if (run) begin
          state_nx = FETCH;
          beat_nx  = '0;
        end
      end

      OPF: begin
        if (is_alu_or_lda(opcode)) begin
          bus.rd = 1'b1;
        end else if (opcode == STO) begin
          bus.datactrl_ena = 1'b1;
        end else if (opcode == JMP) begin
          load_pc = 1'b1;
        end
        state_nx = EXEC;
      end

      EXEC: begin
        if (is_alu_or_lda(opcode)) begin
          bus.rd   = 1'b1;
          load_acc = mem_ok;
          if (mem_ok) begin
            state_nx = WB;
          end
        end else if (opcode == STO) begin
          bus.wr           = 1'b1;
          bus.datactrl_ena = 1'b1;
          if (mem_ok) begin
            state_nx = WB;
          end
        end else if (opcode == JMP) begin
          load_pc  = 1'b1;
          state_nx = WB;
        end else if ((opcode == SKZ) && zero) begin
          state_nx = SKIP;
          beat_nx  = '0;
        end else begin
          state_nx = WB;
        end
      end

      WB: begin
        if (opcode == STO) begin
          bus.datactrl_ena = 1'b1;
        end else if (is_alu_or_lda(opcode)) begin
          bus.rd = 1'b1;
        end
        state_nx = TAIL;
      end

      TAIL: begin
        retire   = 1'b1;
        state_nx = FETCH;
        beat_nx  = '0;
      end

      // Skips a whole instruction: one PC increment per instruction word,
      // reusing the fetch beat counter.
      SKIP: begin
        inc_pc = 1'b1;
        if (beat == LAST_BEAT) begin
          beat_nx  = '0;
          retire   = 1'b1;
          state_nx = FETCH;
        end else begin
          beat_nx = beat + BEAT_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        beat_nx  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_ctrl_param.sv
`timescale 1ns/1ps
module tb_machine_ctrl_param;

  // Instance A: 2-beat fetch, no wait states, 16-bit counter.
  // Instance B: 3-beat fetch, wait states, 4-bit counter (wraps).
  localparam int unsigned A_IRW  = 2;
  localparam bit          A_WEN  = 1'b0;
  localparam int unsigned A_CNTW = 16;
  localparam int unsigned B_IRW  = 3;
  localparam bit          B_WEN  = 1'b1;
  localparam int unsigned B_CNTW = 4;

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

  // Output vector: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactrl_ena, halt}
  localparam logic [7:0] O_INC = 8'h80, O_LACC = 8'h40, O_LPC = 8'h20, O_RD = 8'h10;
  localparam logic [7:0] O_WR  = 8'h08, O_LIR  = 8'h04, O_DEN = 8'h02, O_HALT = 8'h01;

  typedef struct {
    logic        ena;
    logic        run;
    logic        zero;
    logic [2:0]  op;
    logic        mr;
    logic [7:0]  outs;
    int unsigned cnt;
  } cyc_t;

  cyc_t stim_a[$];
  cyc_t stim_b[$];
  cyc_t exp_a[$];
  cyc_t exp_b[$];
  int unsigned cnt_m[2];
  int checks   = 0;
  int failures = 0;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic ena_a = 1'b0, zero_a = 1'b0, run_a = 1'b0;
  logic [2:0] op_a = 3'd0;
  logic inc_a, lacc_a, lpc_a, lir_a, halt_a;
  logic [A_CNTW-1:0] cnt_a;
  logic [7:0] outs_a;

  logic ena_b = 1'b0, zero_b = 1'b0, run_b = 1'b0;
  logic [2:0] op_b = 3'd0;
  logic inc_b, lacc_b, lpc_b, lir_b, halt_b;
  logic [B_CNTW-1:0] cnt_b;
  logic [7:0] outs_b;

  machine_ctrl_param_if bus_a();
  machine_ctrl_param_if bus_b();

  machine_ctrl_param #(.IR_WORDS(A_IRW), .WAIT_EN(A_WEN), .CNT_W(A_CNTW)) dut_a (
    .clk(clk), .ena(ena_a), .zero(zero_a), .opcode(op_a), .run(run_a), .bus(bus_a),
    .inc_pc(inc_a), .load_acc(lacc_a), .load_pc(lpc_a), .load_ir(lir_a),
    .halt(halt_a), .instr_cnt(cnt_a)
  );

  machine_ctrl_param #(.IR_WORDS(B_IRW), .WAIT_EN(B_WEN), .CNT_W(B_CNTW)) dut_b (
    .clk(clk), .ena(ena_b), .zero(zero_b), .opcode(op_b), .run(run_b), .bus(bus_b),
    .inc_pc(inc_b), .load_acc(lacc_b), .load_pc(lpc_b), .load_ir(lir_b),
    .halt(halt_b), .instr_cnt(cnt_b)
  );

  assign outs_a = {inc_a, lacc_a, lpc_a, bus_a.rd, bus_a.wr, lir_a, bus_a.datactrl_ena, halt_a};
  assign outs_b = {inc_b, lacc_b, lpc_b, bus_b.rd, bus_b.wr, lir_b, bus_b.datactrl_ena, halt_b};

  // ---------------- reference model (instruction-level phase lists) --------
  function automatic int irw(input int d);
    return (d == 0) ? int'(A_IRW) : int'(B_IRW);
  endfunction

  function automatic bit wen(input int d);
    return (d == 0) ? A_WEN : B_WEN;
  endfunction

  function automatic int unsigned cnt_mod(input int d);
    return (d == 0) ? (32'd1 << A_CNTW) : (32'd1 << B_CNTW);
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic bit is_mem_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

  task automatic add(input int d, input logic [2:0] op, input logic z, input logic mr,
                     input logic en, input logic rn, input logic [7:0] outs, input bit retire);
    cyc_t e;
    if (!en) cnt_m[d] = 0;
    e.ena = en; e.run = rn; e.zero = z; e.op = op; e.mr = mr; e.outs = outs;
    e.cnt = cnt_m[d];
    if (retire) cnt_m[d] = (cnt_m[d] + 1) % cnt_mod(d);
    if (d == 0) stim_a.push_back(e);
    else        stim_b.push_back(e);
  endtask

  // A cycle outside memory access and HALT: mem_ready and run are noise.
  task automatic plain(input int d, input logic [2:0] op, input logic z,
                       input logic [7:0] outs, input bit retire);
    add(d, op, z, rbit(), 1'b1, rbit(), outs, retire);
  endtask

  task automatic mem_phase(input int d, input logic [2:0] op, input logic z, input int stall,
                           input logic [7:0] wait_o, input logic [7:0] done_o);
    if (wen(d)) begin
      for (int i = 0; i < stall; i++) add(d, op, z, 1'b0, 1'b1, rbit(), wait_o, 1'b0);
      add(d, op, z, 1'b1, 1'b1, rbit(), done_o, 1'b0);
    end else begin
      add(d, op, z, rbit(), 1'b1, rbit(), done_o, 1'b0);
    end
  endtask

  task automatic plan_instr(input int d, input logic [2:0] op, input logic z,
                            input int stall, input int hold, input bit abort);
    int s;
    logic [7:0] o;
    for (int k = 0; k < irw(d); k++) begin
      s = (stall >= 0) ? stall : int'($urandom_range(0, 3));
      mem_phase(d, op, z, s, O_RD, O_RD | O_LIR | ((k >= 1) ? O_INC : 8'h00));
    end
    plain(d, op, z, 8'h00, 1'b0);                       // decode
    if (op == OP_HLT) begin
      plain(d, op, z, O_INC | O_HALT, 1'b1);            // addr, retires
      for (int i = 0; i < hold; i++) add(d, op, z, rbit(), 1'b1, 1'b0, O_HALT, 1'b0);
      add(d, op, z, rbit(), 1'b1, 1'b1, O_HALT, 1'b0);  // resume
      return;
    end
    plain(d, op, z, O_INC, 1'b0);                       // addr
    o = is_mem_op(op) ? O_RD : (op == OP_STO) ? O_DEN : (op == OP_JMP) ? O_LPC : 8'h00;
    plain(d, op, z, o, 1'b0);                           // operand fetch
    s = (stall >= 0) ? stall : int'($urandom_range(0, 3));
    if (is_mem_op(op)) begin
      if (abort) begin
        if (wen(d)) for (int i = 0; i < s; i++) add(d, op, z, 1'b0, 1'b1, 1'b0, O_RD, 1'b0);
        add(d, op, z, rbit(), 1'b0, 1'b0, 8'h00, 1'b0); // ena dropped mid-exec
        add(d, op, z, rbit(), 1'b1, 1'b0, 8'h00, 1'b0); // idle after release
        return;
      end
      mem_phase(d, op, z, s, O_RD, O_RD | O_LACC);
    end else if (op == OP_STO) begin
      mem_phase(d, op, z, s, O_WR | O_DEN, O_WR | O_DEN);
    end else if (op == OP_JMP) begin
      plain(d, op, z, O_LPC, 1'b0);
    end else begin
      plain(d, op, z, 8'h00, 1'b0);
    end
    if ((op == OP_SKZ) && z) begin
      for (int k = 0; k < irw(d); k++) plain(d, op, z, O_INC, k == irw(d) - 1);
      return;
    end
    o = (op == OP_STO) ? O_DEN : is_mem_op(op) ? O_RD : 8'h00;
    plain(d, op, z, o, 1'b0);                           // writeback
    plain(d, op, z, 8'h00, 1'b1);                       // tail, retires
  endtask

  task automatic plan_random(input int d, input int n);
    logic [2:0] op;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      plan_instr(d, op, rbit(), -1, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic plan_all(input int d);
    add(d, OP_ADD, 1'b0, rbit(), 1'b1, 1'b0, 8'h00, 1'b0); // idle after release
    plan_instr(d, OP_ADD, 1'b0, 0, 0, 1'b0);
    plan_instr(d, OP_HLT, 1'b0, 0, 20, 1'b0);
    plan_instr(d, OP_SKZ, 1'b1, 0, 0, 1'b0);
    plan_instr(d, OP_SKZ, 1'b0, 0, 0, 1'b0);
    plan_instr(d, OP_STO, 1'b0, 3, 0, 1'b0);
    plan_instr(d, OP_ADD, 1'b0, 2, 0, 1'b0);
    plan_instr(d, OP_JMP, 1'b1, 0, 0, 1'b0);
    plan_random(d, 25);
    plan_instr(d, OP_LDA, 1'b0, 2, 0, 1'b1);
    plan_random(d, 6);
  endtask

  // ---------------- checking ------------------------------------------------
  task automatic check(input string nm, input int cyc, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // ---------------- drivers: issue stimulus, post expectation ---------------
  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      if (stim_a.size() > 0) begin
        e = stim_a.pop_front();
        ena_a = e.ena; run_a = e.run; zero_a = e.zero; op_a = e.op; bus_a.mem_ready = e.mr;
        exp_a.push_back(e);
      end
    end
  end

  initial begin
    cyc_t e;
    forever begin
      @(posedge clk);
      if (stim_b.size() > 0) begin
        e = stim_b.pop_front();
        ena_b = e.ena; run_b = e.run; zero_b = e.zero; op_b = e.op; bus_b.mem_ready = e.mr;
        exp_b.push_back(e);
      end
    end
  end

  // ---------------- monitors: sample mid-cycle, away from the falling edge --
  initial begin
    cyc_t e;
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("outs_a", n, {24'h0, outs_a}, {24'h0, e.outs});
        check("cnt_a", n, {16'h0, cnt_a}, e.cnt);
        n++;
      end
    end
  end

  initial begin
    cyc_t e;
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("outs_b", n, {24'h0, outs_b}, {24'h0, e.outs});
        check("cnt_b", n, {28'h0, cnt_b}, e.cnt);
        n++;
      end
    end
  end

  // ---------------- main ----------------------------------------------------
  initial begin
    bit busy;
    bus_a.mem_ready = 1'b0;
    bus_b.mem_ready = 1'b0;
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    @(posedge clk);
    #2;
    check("rst_outs_a", 0, {24'h0, outs_a}, 32'h0);
    check("rst_cnt_a", 0, {16'h0, cnt_a}, 32'h0);
    check("rst_outs_b", 0, {24'h0, outs_b}, 32'h0);
    check("rst_cnt_b", 0, {28'h0, cnt_b}, 32'h0);
    plan_all(0);
    plan_all(1);
    busy = 1'b1;
    for (int c = 0; c < 20000 && busy; c++) begin
      @(posedge clk);
      #4;
      busy = (stim_a.size() + stim_b.size() + exp_a.size() + exp_b.size()) != 0;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d want=0", exp_a.size() + exp_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
